// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response handshake and data-memory bus of the load/store unit
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;
  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error, mem_address, mem_write_data, mem_write, mem_read
  );
  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_error, mem_address, mem_write_data, mem_write, mem_read
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: big-endian byte/halfword/word load-store FSM over a word-addressed memory; LSU_MISALIGN_TRAP_EN enables misalignment traps
module load_store_unit #(
  parameter int WORD_IDX_W = 8
) (
  input logic clk,
  input logic reset,
  load_store_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic ready_q, resp_valid_q, mem_read_q, mem_write_q;
  logic [31:0] rdata_q, rdata_d, addr_q, wdata_q, wdata_d;
  logic write_q, unsigned_q;
  logic [1:0] size_q, off_q;
  logic [15:0] st_q;
  logic accept, misalign;
  logic [4:0] shamt;
  logic [31:0] sh, load_val, mask, merged;
  assign accept = bus.req_valid && ready_q;
`ifdef LSU_MISALIGN_TRAP_EN
  logic error_q;
  assign misalign = bus.req_size[1] ? |bus.req_addr[1:0] : bus.req_size[0] & bus.req_addr[0];
  assign bus.resp_error = error_q;
  // Error flag accompanies the DONE pulse of a trapped request only
  always_ff @(posedge clk) begin
    if (reset) error_q <= 1'b0;
    else       error_q <= (state_q == IDLE) && accept && misalign;
  end
`else
  assign misalign = 1'b0;
  assign bus.resp_error = 1'b0;
`endif
  // Big-endian lanes: offset 0 is the most significant byte, so shift right by the distance to bit 0
  assign shamt    = size_q[0] ? {~off_q[1], 4'b0} : {~off_q, 3'b0};
  assign sh       = bus.mem_read_data >> shamt;
  assign load_val = size_q[1] ? bus.mem_read_data :
                    size_q[0] ? {{16{~unsigned_q & sh[15]}}, sh[15:0]} :
                                {{24{~unsigned_q & sh[7]}}, sh[7:0]};
  assign mask     = (size_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << shamt;
  assign merged   = (bus.mem_read_data & ~mask) | ((size_q[0] ? {2{st_q}} : {4{st_q[7:0]}}) & mask);
  // Next state plus next values of the data-carrying output registers
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !accept ? IDLE : misalign ? DONE : (bus.req_write && bus.req_size[1]) ? WRITE : READ;
      READ:    state_d = write_q ? WRITE : DONE;
      WRITE:   state_d = DONE;
      default: state_d = IDLE;
    endcase
    wdata_d = (state_d != WRITE) ? '0 : (state_q == IDLE) ? bus.req_wdata : merged;
    rdata_d = (state_d != DONE) ? rdata_q : (state_q == READ) ? load_val : '0;
  end
  // State and registered outputs; every strobe is decoded from the next state so it is glitch-free
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      rdata_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= state_d == IDLE;
      resp_valid_q <= state_d == DONE;
      mem_read_q   <= state_d == READ;
      mem_write_q  <= state_d == WRITE;
      rdata_q      <= rdata_d;
      wdata_q      <= wdata_d;
      if (accept) addr_q <= 32'(bus.req_addr[WORD_IDX_W+1:2]);
    end
  end
  // Request fields held for the whole transaction
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q    <= bus.req_write;
      size_q     <= bus.req_size;
      unsigned_q <= bus.req_unsigned;
      off_q      <= bus.req_addr[1:0];
      st_q       <= bus.req_wdata[15:0];
    end
  end
  assign bus.req_ready      = ready_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_rdata     = rdata_q;
  assign bus.mem_read       = mem_read_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_address    = addr_q;
  assign bus.mem_write_data = wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: random and directed transactions against a byte-array reference model of memory
module tb_load_store_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  load_store_unit_if bus();
  load_store_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic preload = 1'b0;
  logic [7:0] preload_idx = '0;
  logic [31:0] preload_val = '0;
  int n_tests = 0, n_fail = 0, both_cnt = 0, last_lat = 0;
  logic [31:0] last_rdata, last_addr;
  // Word memory: writes commit on the rising edge unless that edge is a reset edge
  always @(posedge clk) begin
    if (preload) mem[preload_idx] <= preload_val;
    else if (bus.mem_write && !reset) mem[bus.mem_address[7:0]] <= bus.mem_write_data;
  end
  // Read data appears on the falling edge while mem_read is high
  always @(negedge clk) if (bus.mem_read) bus.mem_read_data <= mem[bus.mem_address[7:0]];
  always @(negedge clk) if (bus.mem_read && bus.mem_write) both_cnt++;
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input logic wr, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                     input logic [31:0] wd, input bit hold);
    int idx, o, lat, waited, rd_n, wr_n, busy, e_lat;
    logic [7:0] b [4];
    logic [31:0] w, e_rdata;
    logic [15:0] h;
    logic e_err, e_rd, e_wr;
    idx = int'(addr[9:2]);
    w = ref_mem[idx];
    for (int k = 0; k < 4; k++) b[k] = w[31-8*k -: 8];
    e_err = TRAP && ((sz == 2'd1 && addr[0]) || (sz[1] && addr[1:0] != 2'd0));
    o = sz[1] ? 0 : sz[0] ? int'(addr[1]) * 2 : int'(addr[1:0]);
    h = {b[o], b[(o + 1) % 4]};
    e_rdata = '0;
    e_rd = 1'b0;
    e_wr = 1'b0;
    if (e_err) e_lat = 1;
    else if (!wr) begin
      e_lat = 2;
      e_rd = 1'b1;
      e_rdata = sz[1] ? w : sz[0] ? (uns ? {16'h0, h} : {{16{h[15]}}, h}) : (uns ? {24'h0, b[o]} : {{24{b[o][7]}}, b[o]});
    end else if (sz[1]) begin
      e_lat = 2;
      e_wr = 1'b1;
      ref_mem[idx] = wd;
    end else begin
      e_lat = 3;
      e_rd = 1'b1;
      e_wr = 1'b1;
      if (sz[0]) begin
        b[o] = wd[15:8];
        b[o+1] = wd[7:0];
      end else b[o] = wd[7:0];
      ref_mem[idx] = {b[0], b[1], b[2], b[3]};
    end
    bus.req_write = wr;
    bus.req_size = sz;
    bus.req_unsigned = uns;
    bus.req_addr = addr;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    waited = 0;
    while (!bus.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_wait", waited, 0);
    @(posedge clk);
    #1;
    if (!hold) bus.req_valid = 1'b0;
    lat = 0;
    rd_n = 0;
    wr_n = 0;
    busy = 0;
    last_addr = 'x;
    do begin
      @(negedge clk);
      lat++;
      rd_n += int'(bus.mem_read);
      wr_n += int'(bus.mem_write);
      busy += int'(bus.req_ready);
      if (lat == 1) last_addr = bus.mem_address;
    end while (!bus.resp_valid && lat < 8);
    last_lat = lat;
    last_rdata = bus.resp_rdata;
    chk("latency", lat, e_lat);
    chk("resp_error", {31'b0, bus.resp_error}, {31'b0, e_err});
    chk("resp_rdata", bus.resp_rdata, e_rdata);
    chk("strobes", {rd_n[15:0], wr_n[15:0]}, {15'b0, e_rd, 15'b0, e_wr});
    chk("mem_address", last_addr, 32'(idx));
    chk("ready_busy", busy, 0);
    @(negedge clk);
    chk("resp_pulse", {31'b0, bus.resp_valid}, 32'b0);
    chk("ready_after", {31'b0, bus.req_ready}, 32'b1);
    chk("rdata_hold", bus.resp_rdata, e_rdata);
    chk("mem_word", mem[idx], ref_mem[idx]);
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      preload = 1'b1;
      preload_idx = 8'(i);
      preload_val = $urandom;
      ref_mem[i] = preload_val;
      @(posedge clk);
      #1;
    end
    preload = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, bus.req_ready}, 32'b1);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'b0);
    chk("rst_resp_error", {31'b0, bus.resp_error}, 32'b0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'b0);
    chk("rst_mem_read", {31'b0, bus.mem_read}, 32'b0);
    chk("rst_mem_write", {31'b0, bus.mem_write}, 32'b0);
    chk("rst_mem_address", bus.mem_address, 32'b0);
    chk("rst_mem_wdata", bus.mem_write_data, 32'b0);
    reset = 1'b0;
    run(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
    chk("d_sw_latency", last_lat, 2);
    run(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("d_lw_addr", last_addr, 32'd4);
    chk("d_lw_data", last_rdata, 32'hDEAD_BEEF);
    run(1'b1, 2'd0, 1'b0, 32'h11, 32'h5A, 1'b0);
    chk("d_sb_latency", last_lat, 3);
    chk("d_sb_mem", mem[4], 32'hDE5A_BEEF);
    run(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b0);
    chk("d_lb_signed", last_rdata, 32'hFFFF_FFEF);
    run(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b0);
    chk("d_lhu", last_rdata, 32'h0000_BEEF);
    run(1'b0, 2'd2, 1'b0, 32'h22, 32'h0, 1'b0);
    run(1'b0, 2'd1, 1'b0, 32'h23, 32'h0, 1'b0);
    run(1'b1, 2'd3, 1'b0, 32'h2F, 32'h1234_5678, 1'b0);
    bus.req_write = 1'b1;
    bus.req_size = 2'd2;
    bus.req_addr = 32'h30;
    bus.req_wdata = ~ref_mem[12];
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_write", {31'b0, bus.mem_write}, 32'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready", {31'b0, bus.req_ready}, 32'b1);
    chk("abort_mem_write", {31'b0, bus.mem_write}, 32'b0);
    begin
      int pulses = 0;
      for (int i = 0; i < 4; i++) begin
        pulses += int'(bus.resp_valid);
        @(negedge clk);
      end
      chk("abort_no_resp", pulses, 0);
    end
    chk("abort_mem12", mem[12], ref_mem[12]);
    run(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b1);
    run(1'b1, 2'd2, 1'b0, 32'h44, $urandom, 1'b1);
    run(1'b1, 2'd0, 1'b0, 32'h45, $urandom, 1'b1);
    run(1'b0, 2'd1, 1'b0, 32'h46, 32'h0, 1'b0);
    for (int i = 0; i < 60; i++)
      run(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          32'($urandom_range(0, 1023)), $urandom, 1'($urandom_range(0, 1)));
    bus.req_valid = 1'b0;
    chk("rw_exclusive", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
